// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 24-bit processor: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives the datapath selects, with fetch handshake, memory wait/timeout, program load and HALT.
module multicycle_control_unit #(
    parameter int INST_W      = 24,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    output logic              inst_req,
    input  logic              cmp_flag,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [1:0]        mux1,
    output logic              mux4,
    output logic [1:0]        mux5,
    output logic [1:0]        mux6,
    output logic [2:0]        regs_bank,
    output logic              data_mem,
    output logic [5:0]        alu,
    output logic              comparator,
    output logic              write_inst,
    output logic              pc_en,
    output logic              ir_load,
    output logic              halted,
    output logic              mem_err,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [2:0]        state_dbg
);

    // Handshakes: inst is taken in any FETCH cycle with inst_valid high (inst_req acts as ready);
    // mem_req stays high in MEM until the cycle mem_ack is seen or the timeout fires.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_PROG   = 3'd7
    } state_t;

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, next_state;
    logic [INST_W-1:0] ir;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [1:0]        cls;
    logic [5:0]        fn;
    logic              tmo_hit;
    logic              retire;
    logic              unused_ir_bits;

    assign cls            = ir[INST_W-1 -: 2];
    assign fn             = ir[INST_W-3 -: 6];
    assign unused_ir_bits = ^ir[INST_W-9:0];
    assign state_dbg      = state;

    // An ack arriving in the final allowed cycle suppresses the timeout.
    assign tmo_hit = (state == S_MEM) && !mem_ack && (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ir          <= '0;
            retired_cnt <= '0;
            mem_err     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && inst_valid)
                ir <= inst;
            if (retire)
                retired_cnt <= retired_cnt + CNT_W'(1);
            if (state != S_MEM)
                tmo_cnt <= '0;
            else if (!mem_ack)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = prog_mode ? S_PROG : S_FETCH;
            S_PROG:   next_state = prog_mode ? S_PROG : S_FETCH;
            S_FETCH:  next_state = inst_valid ? S_DECODE : S_FETCH;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                case (cls)
                    2'b00, 2'b01: next_state = S_WB;
                    2'b10:        next_state = S_MEM;
                    default:      next_state = (fn == 6'b111111) ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ack)
                    next_state = fn[0] ? S_FETCH : S_WB;
                else if (tmo_hit)
                    next_state = S_HALT;
            end
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        inst_req   = 1'b0;
        mem_req    = 1'b0;
        mux1       = 2'b00;
        mux4       = 1'b0;
        mux5       = 2'b00;
        mux6       = 2'b00;
        regs_bank  = 3'b000;
        data_mem   = 1'b0;
        alu        = 6'b000000;
        comparator = 1'b0;
        write_inst = 1'b0;
        pc_en      = 1'b0;
        ir_load    = 1'b0;
        halted     = 1'b0;
        retire     = 1'b0;
        case (state)
            S_PROG: write_inst = 1'b1;
            S_FETCH: begin
                inst_req = 1'b1;
                ir_load  = inst_valid;
            end
            S_DECODE: regs_bank = 3'b110;
            S_EXEC: begin
                case (cls)
                    2'b00: alu = fn;
                    2'b01: mux4 = 1'b1;
                    2'b10: begin
                        alu  = 6'b000001;
                        mux4 = 1'b1;
                    end
                    default: begin
                        if (fn == 6'b111111) begin
                            // HALT opcode: nothing retires and the PC holds.
                        end else if (fn[5]) begin
                            mux1   = 2'b10;
                            pc_en  = 1'b1;
                            retire = 1'b1;
                        end else begin
                            comparator = 1'b1;
                            alu        = 6'b000010;
                            mux1       = cmp_flag ? 2'b01 : 2'b00;
                            pc_en      = 1'b1;
                            retire     = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mux4     = 1'b1;
                data_mem = fn[0];
                pc_en    = mem_ack && fn[0];
                retire   = mem_ack && fn[0];
            end
            S_WB: begin
                regs_bank = 3'b001;
                pc_en     = 1'b1;
                retire    = 1'b1;
                case (cls)
                    2'b01:   mux6 = 2'b01;
                    2'b10:   mux6 = 2'b10;
                    default: mux6 = 2'b00;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: inputs change just after the falling edge,
// outputs are checked 1ns later, state advances on the rising edge.
module tb_multicycle_control_unit;

    localparam int INST_W      = 24;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              prog_mode = 1'b0;
    logic [INST_W-1:0] inst = '0;
    logic              inst_valid = 1'b0;
    logic              cmp_flag = 1'b0;
    logic              mem_ack = 1'b0;
    logic              inst_req, mem_req, mux4, data_mem, comparator, write_inst;
    logic              pc_en, ir_load, halted, mem_err;
    logic [1:0]        mux1, mux5, mux6;
    logic [2:0]        regs_bank, state_dbg;
    logic [5:0]        alu;
    logic [CNT_W-1:0]  retired_cnt;

    typedef struct packed {
        logic       inst_req;
        logic       mem_req;
        logic [1:0] mux1;
        logic       mux4;
        logic [1:0] mux5;
        logic [1:0] mux6;
        logic [2:0] regs_bank;
        logic       data_mem;
        logic [5:0] alu;
        logic       comparator;
        logic       write_inst;
        logic       pc_en;
        logic       ir_load;
        logic       halted;
    } ctl_t;

    ctl_t             act, e;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               checks = 0;
    int               fails = 0;

    assign act = {inst_req, mem_req, mux1, mux4, mux5, mux6, regs_bank, data_mem, alu,
                  comparator, write_inst, pc_en, ir_load, halted};

    multicycle_control_unit #(
        .INST_W(INST_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .inst(inst), .inst_valid(inst_valid),
        .inst_req(inst_req), .cmp_flag(cmp_flag), .mem_ack(mem_ack), .mem_req(mem_req),
        .mux1(mux1), .mux4(mux4), .mux5(mux5), .mux6(mux6), .regs_bank(regs_bank),
        .data_mem(data_mem), .alu(alu), .comparator(comparator), .write_inst(write_inst),
        .pc_en(pc_en), .ir_load(ir_load), .halted(halted), .mem_err(mem_err),
        .retired_cnt(retired_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required reaching the summary");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; prog_mode = 1'b0; inst = 24'h0A5000; inst_valid = 1'b1;
        cmp_flag = 1'b1; mem_ack = 1'b1;
        @(negedge clk); #1;
        e = '0;
        checks++;
        if (act !== e || state_dbg !== 3'd0) begin
            fails++; $display("FAIL reset_outputs: ctl=%h state=%0d, want ctl=%h state=0", act, state_dbg, e);
        end
        checks++;
        if (retired_cnt !== 4'd0 || mem_err !== 1'b0) begin
            fails++; $display("FAIL reset_regs: cnt=%0d mem_err=%b, want 0 0", retired_cnt, mem_err);
        end
        @(negedge clk); rst_n = 1'b1; cmp_flag = 1'b0; mem_ack = 1'b0; #1;
        exp_cnt = '0;
        checks++;
        if (act !== e || state_dbg !== 3'd0) begin
            fails++; $display("FAIL reset_idle: ctl=%h state=%0d, want ctl=%h state=0", act, state_dbg, e);
        end
    endtask

    // ALU (cls 00) and constant (cls 01) instructions: FETCH, DECODE, EXEC, WB.
    task automatic test_alu_const(input logic [23:0] i, input logic [5:0] x_alu,
                                  input logic x_mux4, input logic [1:0] x_mux6);
        @(negedge clk); inst = i; inst_valid = 1'b1; #1;
        e = '0; e.inst_req = 1'b1; e.ir_load = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd1) begin
            fails++; $display("FAIL alu_fetch %h: ctl=%h state=%0d, want ctl=%h state=1", i, act, state_dbg, e);
        end
        @(negedge clk); inst_valid = 1'b0; #1;
        e = '0; e.regs_bank = 3'b110;
        checks++;
        if (act !== e || state_dbg !== 3'd2) begin
            fails++; $display("FAIL alu_decode %h: ctl=%h state=%0d, want ctl=%h state=2", i, act, state_dbg, e);
        end
        @(negedge clk); #1;
        e = '0; e.alu = x_alu; e.mux4 = x_mux4;
        checks++;
        if (act !== e || state_dbg !== 3'd3) begin
            fails++; $display("FAIL alu_exec %h: ctl=%h state=%0d, want ctl=%h state=3", i, act, state_dbg, e);
        end
        @(negedge clk); #1;
        e = '0; e.regs_bank = 3'b001; e.mux6 = x_mux6; e.pc_en = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd5 || retired_cnt !== exp_cnt) begin
            fails++; $display("FAIL alu_wb %h: ctl=%h state=%0d cnt=%0d, want ctl=%h state=5 cnt=%0d",
                              i, act, state_dbg, retired_cnt, e, exp_cnt);
        end
        @(negedge clk); #1;
        exp_cnt++;
        e = '0; e.inst_req = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd1 || retired_cnt !== exp_cnt) begin
            fails++; $display("FAIL alu_retire %h: ctl=%h state=%0d cnt=%0d, want ctl=%h state=1 cnt=%0d",
                              i, act, state_dbg, retired_cnt, e, exp_cnt);
        end
    endtask

    // Load/store with mem_ack raised after 'waits' MEM cycles without it.
    task automatic test_mem(input logic [23:0] i, input int waits);
        logic st;
        st = i[16];
        @(negedge clk); inst = i; inst_valid = 1'b1; #1;
        e = '0; e.inst_req = 1'b1; e.ir_load = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd1) begin
            fails++; $display("FAIL mem_fetch %h: ctl=%h state=%0d, want ctl=%h state=1", i, act, state_dbg, e);
        end
        @(negedge clk); inst_valid = 1'b0; #1;
        @(negedge clk); #1;
        e = '0; e.alu = 6'b000001; e.mux4 = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd3) begin
            fails++; $display("FAIL mem_exec %h: ctl=%h state=%0d, want ctl=%h state=3", i, act, state_dbg, e);
        end
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk); mem_ack = (k == waits); #1;
            e = '0; e.mem_req = 1'b1; e.mux4 = 1'b1; e.data_mem = st; e.pc_en = st && (k == waits);
            checks++;
            if (act !== e || state_dbg !== 3'd4) begin
                fails++; $display("FAIL mem_wait %h cycle %0d: ctl=%h state=%0d, want ctl=%h state=4",
                                  i, k, act, state_dbg, e);
            end
        end
        @(negedge clk); mem_ack = 1'b0; #1;
        if (!st) begin
            e = '0; e.regs_bank = 3'b001; e.mux6 = 2'b10; e.pc_en = 1'b1;
            checks++;
            if (act !== e || state_dbg !== 3'd5) begin
                fails++; $display("FAIL load_wb %h: ctl=%h state=%0d, want ctl=%h state=5", i, act, state_dbg, e);
            end
            @(negedge clk); #1;
        end
        exp_cnt++;
        e = '0; e.inst_req = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd1 || retired_cnt !== exp_cnt || mem_err !== 1'b0) begin
            fails++; $display("FAIL mem_retire %h: ctl=%h state=%0d cnt=%0d err=%b, want ctl=%h state=1 cnt=%0d err=0",
                              i, act, state_dbg, retired_cnt, mem_err, e, exp_cnt);
        end
    endtask

    // Branch (cls 11, fn[5]=0) and jump (fn[5]=1): retire straight from EXEC.
    task automatic test_branch_jump(input logic [23:0] i, input logic cmp);
        logic jmp;
        jmp = i[21];
        @(negedge clk); inst = i; inst_valid = 1'b1; #1;
        @(negedge clk); inst_valid = 1'b0; #1;
        e = '0; e.regs_bank = 3'b110;
        checks++;
        if (act !== e || state_dbg !== 3'd2) begin
            fails++; $display("FAIL br_decode %h: ctl=%h state=%0d, want ctl=%h state=2", i, act, state_dbg, e);
        end
        @(negedge clk); cmp_flag = cmp; #1;
        e = '0; e.pc_en = 1'b1;
        if (jmp) e.mux1 = 2'b10;
        else begin
            e.comparator = 1'b1; e.alu = 6'b000010; e.mux1 = cmp ? 2'b01 : 2'b00;
        end
        checks++;
        if (act !== e || state_dbg !== 3'd3) begin
            fails++; $display("FAIL br_exec %h cmp=%b: ctl=%h state=%0d, want ctl=%h state=3",
                              i, cmp, act, state_dbg, e);
        end
        @(negedge clk); cmp_flag = 1'b0; #1;
        exp_cnt++;
        e = '0; e.inst_req = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd1 || retired_cnt !== exp_cnt) begin
            fails++; $display("FAIL br_retire %h: ctl=%h state=%0d cnt=%0d, want ctl=%h state=1 cnt=%0d",
                              i, act, state_dbg, retired_cnt, e, exp_cnt);
        end
    endtask

    task automatic test_halt_inst();
        @(negedge clk); inst = 24'hFF0000; inst_valid = 1'b1; #1;
        @(negedge clk); inst_valid = 1'b0; #1;
        @(negedge clk); #1;
        e = '0;
        checks++;
        if (act !== e || state_dbg !== 3'd3) begin
            fails++; $display("FAIL halt_exec: ctl=%h state=%0d, want ctl=%h state=3", act, state_dbg, e);
        end
        e = '0; e.halted = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); inst_valid = k[0]; inst = 24'h0A5000; #1;
            checks++;
            if (act !== e || state_dbg !== 3'd6 || retired_cnt !== exp_cnt) begin
                fails++; $display("FAIL halt_hold cycle %0d: ctl=%h state=%0d cnt=%0d, want ctl=%h state=6 cnt=%0d",
                                  k, act, state_dbg, retired_cnt, e, exp_cnt);
            end
        end
        inst_valid = 1'b0;
    endtask

    task automatic test_reset_pulse();
        @(negedge clk); rst_n = 1'b0; #1;
        e = '0; exp_cnt = '0;
        checks++;
        if (act !== e || state_dbg !== 3'd0 || retired_cnt !== exp_cnt || mem_err !== 1'b0) begin
            fails++; $display("FAIL reset_pulse: ctl=%h state=%0d cnt=%0d err=%b, want ctl=0 state=0 cnt=0 err=0",
                              act, state_dbg, retired_cnt, mem_err);
        end
        @(negedge clk); rst_n = 1'b1; #1;
    endtask

    task automatic test_prog();
        @(negedge clk); rst_n = 1'b0; prog_mode = 1'b1; #1;
        @(negedge clk); rst_n = 1'b1; #1;
        exp_cnt = '0;
        e = '0;
        checks++;
        if (act !== e || state_dbg !== 3'd0) begin
            fails++; $display("FAIL prog_idle: ctl=%h state=%0d, want ctl=%h state=0", act, state_dbg, e);
        end
        e = '0; e.write_inst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); if (k == 3) prog_mode = 1'b0; #1;
            checks++;
            if (act !== e || state_dbg !== 3'd7) begin
                fails++; $display("FAIL prog_hold cycle %0d: ctl=%h state=%0d, want ctl=%h state=7",
                                  k, act, state_dbg, e);
            end
        end
        @(negedge clk); #1;
        e = '0; e.inst_req = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd1) begin
            fails++; $display("FAIL prog_exit: ctl=%h state=%0d, want ctl=%h state=1", act, state_dbg, e);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 16; k++) test_branch_jump(24'hE00000, 1'b0);
        checks++;
        if (retired_cnt !== 4'd0) begin
            fails++; $display("FAIL cnt_wrap: cnt=%0d, want 0", retired_cnt);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk); inst = 24'hE00000; inst_valid = 1'b1; #1;
        @(negedge clk); inst_valid = 1'b0; #1;
        @(negedge clk); rst_n = 1'b0; #1;
        e = '0;
        checks++;
        if (act !== e || state_dbg !== 3'd0 || retired_cnt !== 4'd0) begin
            fails++; $display("FAIL mid_reset: ctl=%h state=%0d cnt=%0d, want ctl=0 state=0 cnt=0",
                              act, state_dbg, retired_cnt);
        end
        @(negedge clk); rst_n = 1'b1; exp_cnt = '0; #1;
    endtask

    task automatic test_timeout();
        @(negedge clk); inst = 24'h800000; inst_valid = 1'b1; #1;
        @(negedge clk); inst_valid = 1'b0; #1;
        @(negedge clk); #1;
        e = '0; e.mem_req = 1'b1; e.mux4 = 1'b1;
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            @(negedge clk); #1;
            checks++;
            if (act !== e || state_dbg !== 3'd4 || mem_err !== 1'b0) begin
                fails++; $display("FAIL tmo_wait cycle %0d: ctl=%h state=%0d err=%b, want ctl=%h state=4 err=0",
                                  k, act, state_dbg, mem_err, e);
            end
        end
        @(negedge clk); #1;
        e = '0; e.halted = 1'b1;
        checks++;
        if (act !== e || state_dbg !== 3'd6 || mem_err !== 1'b1 || retired_cnt !== exp_cnt) begin
            fails++; $display("FAIL tmo_halt: ctl=%h state=%0d err=%b cnt=%0d, want ctl=%h state=6 err=1 cnt=%0d",
                              act, state_dbg, mem_err, retired_cnt, e, exp_cnt);
        end
        @(negedge clk); mem_ack = 1'b1; inst_valid = 1'b1; #1;
        checks++;
        if (act !== e || state_dbg !== 3'd6 || mem_err !== 1'b1) begin
            fails++; $display("FAIL tmo_sticky: ctl=%h state=%0d err=%b, want ctl=%h state=6 err=1",
                              act, state_dbg, mem_err, e);
        end
        mem_ack = 1'b0; inst_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_const(24'h0A5000, 6'b001010, 1'b0, 2'b00);
        test_alu_const(24'h450000, 6'b000000, 1'b1, 2'b01);
        test_mem(24'h800000, 3);
        test_mem(24'h810000, 2);
        test_mem(24'h810000, 0);
        test_branch_jump(24'hC00000, 1'b1);
        test_branch_jump(24'hC00000, 1'b0);
        test_branch_jump(24'hE00000, 1'b1);
        test_mem(24'h800000, MEM_TIMEOUT - 1);
        test_halt_inst();
        test_reset_pulse();
        test_prog();
        test_wrap();
        test_mid_reset();
        test_timeout();
        test_reset_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
